// File: rtl/ram_v3_pkg.sv
// Shared constants, fill-state encoding and sizing helper for the ram_v3 block RAM.
package ram_v3_pkg;

  localparam int unsigned INIT_NONE  = 0;
  localparam int unsigned INIT_ZERO  = 1;
  localparam int unsigned INIT_IDENT = 2;

  typedef enum logic {
    FILL  = 1'b0,
    READY = 1'b1
  } fill_state_e;

  function automatic int unsigned depth_of(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

endpackage

// File: rtl/ram_v3_fill_fsm.sv
// Post-reset fill engine: walks every address once, writing zero or the address itself.
module ram_v3_fill_fsm
  import ram_v3_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned INIT_MODE  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  fill_we,
  output logic [ADDR_WIDTH-1:0] fill_addr,
  output logic [DATA_WIDTH-1:0] fill_data,
  output logic                  busy
);

  localparam int unsigned DEPTH = depth_of(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam fill_state_e RST_STATE = (INIT_MODE != INIT_NONE) ? FILL : READY;

  fill_state_e           r_state;
  fill_state_e           w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [ADDR_WIDTH-1:0] w_cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RST_STATE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Leave FILL after the last address is written; the counter never wraps.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      FILL: begin
        w_cnt_nxt = r_cnt + ADDR_WIDTH'(1);
        if (r_cnt == LAST_ADDR) begin
          w_state_nxt = READY;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = r_state;
      end
    endcase
  end

  assign busy      = (r_state == FILL);
  assign fill_we   = busy;
  assign fill_addr = r_cnt;
  assign fill_data = (INIT_MODE == INIT_IDENT) ? DATA_WIDTH'(r_cnt) : '0;

endmodule

// File: rtl/ram_v3.sv
// Simple-dual-port block RAM: byte strobes, selectable read-during-write,
// optional second output register and a synthesizable post-reset fill.
module ram_v3
  import ram_v3_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RDW_MODE   = 0,
  parameter int unsigned OUT_REG    = 0,
  parameter int unsigned INIT_MODE  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   raddr,
  input  logic                    re,
  input  logic [ADDR_WIDTH-1:0]   waddr,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic [DATA_WIDTH-1:0]   din,
  output logic [DATA_WIDTH-1:0]   dout,
  output logic                    dout_valid,
  output logic                    init_busy
);

  localparam int unsigned DEPTH = depth_of(ADDR_WIDTH);
  localparam int unsigned NB    = DATA_WIDTH / 8;

  generate
    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH == 0) begin : g_bad_width
      $error("ram_v3: DATA_WIDTH must be a non-zero multiple of 8");
    end
  endgenerate

  logic                  w_fill_we;
  logic [ADDR_WIDTH-1:0] w_fill_addr;
  logic [DATA_WIDTH-1:0] w_fill_data;
  logic                  w_busy;

  ram_v3_fill_fsm #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .INIT_MODE  (INIT_MODE)
  ) u_fill (
    .clk       (clk),
    .rst       (rst),
    .fill_we   (w_fill_we),
    .fill_addr (w_fill_addr),
    .fill_data (w_fill_data),
    .busy      (w_busy)
  );

  assign init_busy = w_busy;

  logic                  w_rd_acc;
  logic                  w_wr_acc;
  logic                  w_mem_we;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [DATA_WIDTH-1:0] w_mem_data;
  logic [NB-1:0]         w_mem_strb;

  assign w_rd_acc = re & ~w_busy & ~rst;
  assign w_wr_acc = we & ~w_busy & ~rst;

  // The fill engine owns the write port while busy; user requests are dropped.
  always_comb begin
    w_mem_we   = w_wr_acc;
    w_mem_addr = waddr;
    w_mem_data = din;
    w_mem_strb = wstrb;
    if (w_busy) begin
      w_mem_we   = w_fill_we & ~rst;
      w_mem_addr = w_fill_addr;
      w_mem_data = w_fill_data;
      w_mem_strb = '1;
    end
  end

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int k = 0; k < int'(NB); k++) begin
        if (w_mem_strb[k]) begin
          r_mem[w_mem_addr][8*k +: 8] <= w_mem_data[8*k +: 8];
        end
      end
    end
  end

  logic [DATA_WIDTH-1:0] w_rd_word;

  // Write-first collisions forward the strobed bytes of din over the old word.
  always_comb begin
    w_rd_word = r_mem[raddr];
    if (RDW_MODE == 1 && w_wr_acc && (waddr == raddr)) begin
      for (int k = 0; k < int'(NB); k++) begin
        if (wstrb[k]) begin
          w_rd_word[8*k +: 8] = din[8*k +: 8];
        end
      end
    end
  end

  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_rd_data <= w_rd_word;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] r_out_data;
      logic                  r_out_valid;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_out_data  <= '0;
          r_out_valid <= 1'b0;
        end else begin
          r_out_valid <= r_rd_valid;
          if (r_rd_valid) begin
            r_out_data <= r_rd_data;
          end
        end
      end

      assign dout       = r_out_data;
      assign dout_valid = r_out_valid;
    end else begin : g_no_out_reg
      assign dout       = r_rd_data;
      assign dout_valid = r_rd_valid;
    end
  endgenerate

endmodule

// File: tb/tb_ram_v3.sv
// Drives two ram_v3 configurations with shared stimulus and compares both
// against a word-level reference model of fill, strobed writes and read latency.
module tb_ram_v3;

  logic        clk;
  logic        rst;
  logic [3:0]  raddr;
  logic        re;
  logic [3:0]  waddr;
  logic        we;
  logic [3:0]  wstrb;
  logic [31:0] din;

  logic [31:0] dout_a, dout_b;
  logic        dv_a, dv_b;
  logic        busy_a, busy_b;

  int n_checks = 0;
  int n_fail   = 0;

  // A: read-first, single register, identity fill. B: write-first, two registers, zero fill.
  ram_v3 #(
    .ADDR_WIDTH (4), .DATA_WIDTH (32), .RDW_MODE (0), .OUT_REG (0), .INIT_MODE (2)
  ) u_dut_a (
    .clk (clk), .rst (rst), .raddr (raddr), .re (re), .waddr (waddr), .we (we),
    .wstrb (wstrb), .din (din), .dout (dout_a), .dout_valid (dv_a), .init_busy (busy_a)
  );

  ram_v3 #(
    .ADDR_WIDTH (4), .DATA_WIDTH (32), .RDW_MODE (1), .OUT_REG (1), .INIT_MODE (1)
  ) u_dut_b (
    .clk (clk), .rst (rst), .raddr (raddr), .re (re), .waddr (waddr), .we (we),
    .wstrb (wstrb), .din (din), .dout (dout_b), .dout_valid (dv_b), .init_busy (busy_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Reference model state, index 0 = A, 1 = B
  logic [31:0] m_mem [2][16];
  int          m_fill = 0;
  logic        m_pv [2];
  logic [31:0] m_pd [2];
  logic        m_ev [2];
  logic [31:0] m_ed [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  task automatic model_edge();
    logic        v;
    logic [31:0] d;
    for (int k = 0; k < 2; k++) begin
      v = 1'b0;
      d = 32'h0;
      if (rst) begin
        m_pv[k] = 1'b0; m_pd[k] = 32'h0; m_ev[k] = 1'b0; m_ed[k] = 32'h0;
      end else begin
        if (m_fill > 0) begin
          m_mem[k][16 - m_fill] = (k == 0) ? 32'(16 - m_fill) : 32'h0;
        end else begin
          if (re) begin
            v = 1'b1;
            d = m_mem[k][raddr];
            if (k == 1 && we && waddr == raddr) d = merge(d, din, wstrb);
          end
          if (we) m_mem[k][waddr] = merge(m_mem[k][waddr], din, wstrb);
        end
        if (k == 1) begin
          m_ev[k] = m_pv[k];
          if (m_pv[k]) m_ed[k] = m_pd[k];
          m_pv[k] = v;
          m_pd[k] = d;
        end else begin
          m_ev[k] = v;
          if (v) m_ed[k] = d;
        end
      end
    end
    if (rst) m_fill = 16;
    else if (m_fill > 0) m_fill--;
  endtask

  task automatic check_outputs();
    chk("dout_a", dout_a, m_ed[0]);
    chk("valid_a", 32'(dv_a), 32'(m_ev[0]));
    chk("busy_a", 32'(busy_a), 32'(m_fill > 0));
    chk("dout_b", dout_b, m_ed[1]);
    chk("valid_b", 32'(dv_b), 32'(m_ev[1]));
    chk("busy_b", 32'(busy_b), 32'(m_fill > 0));
  endtask

  // One clock: apply inputs, step the model at the edge, check at the falling edge.
  task automatic cyc(input logic i_rst, input logic i_re, input logic [3:0] i_ra,
                     input logic i_we, input logic [3:0] i_wa, input logic [3:0] i_ws,
                     input logic [31:0] i_din);
    rst = i_rst; re = i_re; raddr = i_ra; we = i_we; waddr = i_wa; wstrb = i_ws; din = i_din;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 32'h0);
  endtask

  task automatic rd(input logic [3:0] a);
    cyc(1'b0, 1'b1, a, 1'b0, 4'h0, 4'h0, 32'h0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [3:0] s, input logic [31:0] d);
    cyc(1'b0, 1'b0, 4'h0, 1'b1, a, s, d);
  endtask

  task automatic cyc_rand(input logic i_rst);
    cyc(i_rst, 1'($urandom), 4'($urandom), 1'($urandom), 4'($urandom),
        4'($urandom), 32'($urandom));
  endtask

  // Counts rising edges from the first rst=0 cycle until init_busy drops.
  task automatic wait_fill(input bit noisy, output int n);
    n = 0;
    do begin
      if (noisy) cyc_rand(1'b0);
      else idle();
      n++;
    end while (busy_a && n < 40);
  endtask

  initial begin
    int n;
    rst = 1'b1; re = 1'b0; we = 1'b0; raddr = '0; waddr = '0; wstrb = '0; din = '0;

    cyc(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 32'h0);
    cyc(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 32'h0);
    chk("rst_dout_b", dout_b, 32'h0);
    chk("rst_valid_b", 32'(dv_b), 32'h0);
    chk("rst_busy_a", 32'(busy_a), 32'h1);

    wait_fill(1'b0, n);
    chk("fill_len", 32'(n), 32'd16);

    for (int i = 0; i < 16; i++) begin
      rd(4'(i));
      chk("ident_a", dout_a, 32'(i));
      chk("ident_valid_a", 32'(dv_a), 32'h1);
    end
    idle();
    chk("zero_b_last", dout_b, 32'h0);
    idle();

    wr(4'd3, 4'b0101, 32'hAABBCCDD);
    rd(4'd3);
    chk("strb_a", dout_a, 32'h00BB00DD);
    idle();
    chk("strb_b", dout_b, 32'h00BB00DD);
    wr(4'd3, 4'b0000, 32'h12345678);
    rd(4'd3);
    chk("strb0_a", dout_a, 32'h00BB00DD);
    idle();
    chk("strb0_b", dout_b, 32'h00BB00DD);

    wr(4'd5, 4'hF, 32'h11111111);
    cyc(1'b0, 1'b1, 4'd5, 1'b1, 4'd5, 4'hF, 32'h22222222);
    chk("coll_a", dout_a, 32'h11111111);
    idle();
    chk("coll_b", dout_b, 32'h22222222);
    rd(4'd5);
    chk("after_coll_a", dout_a, 32'h22222222);
    idle();
    chk("after_coll_b", dout_b, 32'h22222222);

    rd(4'd1);
    chk("pipe_v0_b", 32'(dv_b), 32'h0);
    rd(4'd2);
    chk("pipe_d1_b", dout_b, 32'h0);
    rd(4'd3);
    chk("pipe_d2_b", dout_b, 32'h0);
    idle();
    chk("pipe_d3_b", dout_b, 32'h00BB00DD);
    idle();
    chk("pipe_hold_b", dout_b, 32'h00BB00DD);
    chk("pipe_hold_v_b", 32'(dv_b), 32'h0);

    // Reset in the middle of a fill, then hammer the ports while it reruns.
    rd(4'd2);
    cyc(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 32'h0);
    for (int i = 0; i < 7; i++) idle();
    cyc(1'b1, 1'b1, 4'd3, 1'b1, 4'd3, 4'hF, 32'hDEADBEEF);
    chk("midfill_dout_a", dout_a, 32'h0);
    chk("midfill_busy_a", 32'(busy_a), 32'h1);
    wait_fill(1'b1, n);
    chk("refill_len", 32'(n), 32'd16);
    for (int i = 0; i < 16; i++) rd(4'(i));
    idle();

    for (int i = 0; i < 2000; i++) cyc_rand(($urandom_range(0, 399) == 0) ? 1'b1 : 1'b0);
    for (int i = 0; i < 40; i++) idle();
    for (int i = 0; i < 16; i++) rd(4'(i));
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_v3.md
# ram_v3

Parametrised simple-dual-port block RAM with registered read.
- Adds per-byte write strobes, selectable read-during-write behaviour, an optional output pipeline stage and a sequential post-reset fill engine (zero or identity table).
- Serves as the storage primitive under FIFOs, lookup tables and per-core state arrays in the FPGA runtime.
- Replaces ad-hoc `initial`-block initialisation with a synthesizable fill that reruns on every reset.

## Interface
Parameters:
- ADDR_WIDTH, 8, address bits; DEPTH = 2**ADDR_WIDTH.
- DATA_WIDTH, 32, word width; must be a multiple of 8 (elaboration-time error otherwise).
- RDW_MODE, 0, same-address read/write collision: 0 = read-first (old data), 1 = write-first (merged new data).
- OUT_REG, 0, 1 adds a second output register stage.
- INIT_MODE, 0, post-reset fill: 0 = none, 1 = zero, 2 = identity (mem[i] = i, zero-extended or truncated to DATA_WIDTH).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- raddr  in  ADDR_WIDTH  read address.
- re  in  1  read enable.
- waddr  in  ADDR_WIDTH  write address.
- we  in  1  write enable.
- wstrb  in  DATA_WIDTH/8  byte write strobes; bit k covers din[8k+7:8k].
- din  in  DATA_WIDTH  write data.
- dout  out  DATA_WIDTH  read data.
- dout_valid  out  1  dout carries the result of an accepted read this cycle.
- init_busy  out  1  fill engine active; re/we ignored.

## Operation
- **Fill FSM states:** FILL, READY.
  - Reset enters FILL if INIT_MODE != 0, otherwise READY.
  - In FILL, a counter starting at 0 writes one word per cycle: 0 for zero mode, the counter value for identity mode.
  - After writing DEPTH-1, the FSM moves to READY. Counter wrap is not used.
- **Access gating:** In FILL, re, we and wstrb are ignored. No read is accepted and dout_valid stays 0.
- **Write (READY):** When we=1, byte k of mem[waddr] is updated only when wstrb[k]=1. we=1 with wstrb=0 leaves memory unchanged.
- **Read (READY):** When re=1, the read of mem[raddr] is accepted.
  - When re=0, dout holds its last value and dout_valid=0.
- **Collision** (re & we, raddr==waddr, same cycle):
  - RDW_MODE 0: returns the pre-write word.
  - RDW_MODE 1: returns the pre-write word with the strobed bytes replaced by din.
- **Simultaneous reads/writes to different addresses:** fully independent.
- **Reset mid-operation:**
  - In-flight reads are dropped.
  - Memory contents are not cleared unless INIT_MODE != 0, in which case the fill restarts from address 0.

## Timing
- **Reset values:** dout = 0 and dout_valid = 0, including the OUT_REG stage. init_busy = 1 if INIT_MODE != 0, else 0.
- **Fill duration:** exactly DEPTH cycles after the first cycle with rst=0. init_busy falls on the cycle the FSM enters READY, and re/we are accepted that same cycle.
- **Read latency:** 1 + OUT_REG cycles from re sampled high to dout/dout_valid. Reads are fully pipelined, one per cycle.
- **Write visibility:** a write in cycle N is visible to a non-colliding read accepted in cycle N+1.
- **Ordering:** dout_valid follows re exactly, delayed by the latency, with no reordering.

## Structure
- Package ram_v3_pkg holds:
  - the init-mode constants (INIT_NONE, INIT_ZERO, INIT_IDENT);
  - the fill state enum (FILL, READY);
  - a function computing DEPTH from ADDR_WIDTH.
- Sub-module ram_v3_fill_fsm contains the state register and address counter. It outputs fill_we, fill_addr, fill_data and busy.
- The top level muxes the fill port onto the write port and contains the array (block-RAM style), strobe merge, collision bypass and output pipeline.

## Test plan
- **Identity fill:** ADDR_WIDTH=4, DATA_WIDTH=32, INIT_MODE=2. Release rst.
  - init_busy is high for exactly 16 cycles.
  - Reads of addresses 0..15 return 0x0..0xF with dout_valid one cycle after each re.
- **Byte strobes:** after zero fill, write 0xAABBCCDD to addr 3 with wstrb=4'b0101.
  - A read of addr 3 returns 0x00BB00DD.
  - Then write with wstrb=0; a re-read still returns 0x00BB00DD.
- **Collision:** addr 5 holds 0x11111111. Same-cycle write 0x22222222 (wstrb=all ones) and read of addr 5.
  - RDW_MODE=0 returns 0x11111111.
  - RDW_MODE=1 returns 0x22222222.
  - The next read returns 0x22222222 in both modes.
- **Pipelined reads with OUT_REG=1:** issue back-to-back reads of addrs 1, 2, 3.
  - Data appears 2 cycles after each re, on consecutive cycles.
  - dout holds the addr-3 data after re drops.
- **Reset mid-fill:** assert rst at fill count 7 with DEPTH=16.
  - dout and dout_valid clear.
  - init_busy stays 1 and the fill restarts at 0, ending exactly 16 cycles after rst falls.
  - re/we issued during the fill have no effect.
